// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : Execute-to-memory pipeline stage. Resolves CBZ/CBNZ from the ALU
//            zero flag, runs LDUR/STUR req/ack transactions against data
//            memory and produces the register-file write-back.
//            Optional feature macro: EX_MEM_TIMEOUT_EN (ack timeout fault).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  // execute stage
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_aluResult,
  input  logic        ex_zeroFlag,
  input  logic        ex_overflow,
  input  logic [31:0] ex_storeData,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic        ex_branch,
  input  logic        ex_regWrite,
  input  logic [4:0]  ex_rd,
  // data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // write-back
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regWrite,
  output logic        wb_overflow,
  output logic        branch_taken,
  output logic        fault
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;

  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_ovf;

  assign ex_ready   = (r_state == ST_IDLE);
  assign w_accept   = ex_valid && ex_ready;
  assign w_is_mem   = ex_memRead | ex_memWrite;
  assign w_misalign = (ex_aluResult[1:0] != 2'b00);
  assign w_start    = w_accept && w_is_mem && !w_misalign;
  assign w_ack      = (r_state == ST_ACCESS) && mem_ack;

`ifdef EX_MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // An ack arriving on the terminal count takes priority over the timeout.
  assign w_timeout = (r_state == ST_ACCESS) && !mem_ack && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !mem_ack && !w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack)        w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs; wb_valid / branch_taken / fault are single-cycle pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_regWrite  <= 1'b0;
      wb_overflow  <= 1'b0;
      branch_taken <= 1'b0;
      fault        <= 1'b0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      branch_taken <= 1'b0;
      fault        <= 1'b0;

      if (w_accept) begin
        if (!w_is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= ex_aluResult;
          wb_rd        <= ex_rd;
          wb_regWrite  <= ex_regWrite;
          wb_overflow  <= ex_overflow;
          branch_taken <= ex_branch && ex_zeroFlag;
        end else if (w_misalign) begin
          wb_valid     <= 1'b1;
          wb_data      <= ex_aluResult;
          wb_rd        <= ex_rd;
          wb_regWrite  <= 1'b0;
          wb_overflow  <= ex_overflow;
          fault        <= 1'b1;
        end else begin
          // A write takes precedence when both memRead and memWrite are set.
          mem_req      <= 1'b1;
          mem_we       <= ex_memWrite;
          mem_addr     <= ex_aluResult;
          mem_wdata    <= ex_storeData;
          r_rd         <= ex_rd;
          r_regwrite   <= ex_regWrite && !ex_memWrite;
          r_ovf        <= ex_overflow;
        end
      end

      if (w_ack) begin
        mem_req      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_data      <= mem_we ? mem_addr : mem_rdata;
        wb_rd        <= r_rd;
        wb_regWrite  <= r_regwrite;
        wb_overflow  <= r_ovf;
      end else if (w_timeout) begin
        mem_req      <= 1'b0;
        wb_valid     <= 1'b1;
        wb_data      <= mem_addr;
        wb_rd        <= r_rd;
        wb_regWrite  <= 1'b0;
        wb_overflow  <= r_ovf;
        fault        <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Brief    : Self-checking bench for ex_mem_stage (vector table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_aluResult;
  logic        ex_zeroFlag;
  logic        ex_overflow;
  logic [31:0] ex_storeData;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_branch;
  logic        ex_regWrite;
  logic [4:0]  ex_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regWrite;
  logic        wb_overflow;
  logic        branch_taken;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluResult(ex_aluResult), .ex_zeroFlag(ex_zeroFlag),
    .ex_overflow(ex_overflow), .ex_storeData(ex_storeData),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_branch(ex_branch), .ex_regWrite(ex_regWrite), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_regWrite(wb_regWrite), .wb_overflow(wb_overflow),
    .branch_taken(branch_taken), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic        ovf;
    logic        br;
    logic        mrd;
    logic        mwr;
    logic        rw;
    logic [4:0]  rd;
    logic        e_bt;
    logic        e_fault;
    logic        e_rw;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid     = 1'b0;
    ex_aluResult = '0;
    ex_zeroFlag  = 1'b0;
    ex_overflow  = 1'b0;
    ex_storeData = '0;
    ex_memRead   = 1'b0;
    ex_memWrite  = 1'b0;
    ex_branch    = 1'b0;
    ex_regWrite  = 1'b0;
    ex_rd        = '0;
  endtask

  // Issue one memory op, ack after k wait cycles, check each cycle.
  task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic rd_en, input logic wr_en,
                        input logic rw, input logic br, input logic [4:0] rd, input int k,
                        input logic e_we, input logic e_rw, input logic [31:0] e_data);
    ex_valid     = 1'b1;
    ex_aluResult = addr;
    ex_storeData = wdata;
    ex_memRead   = rd_en;
    ex_memWrite  = wr_en;
    ex_regWrite  = rw;
    ex_branch    = br;
    ex_zeroFlag  = 1'b1;
    ex_rd        = rd;
    @(posedge clk); #1;
    drive_idle();
    chk({tag, "_req"},   mem_req,   1);
    chk({tag, "_ready"}, ex_ready,  0);
    chk({tag, "_addr"},  mem_addr,  addr);
    chk({tag, "_we"},    mem_we,    e_we);
    chk({tag, "_wdata"}, mem_wdata, wdata);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      chk({tag, "_req_wait"},   mem_req,  1);
      chk({tag, "_ready_wait"}, ex_ready, 0);
      chk({tag, "_wbv_wait"},   wb_valid, 0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk({tag, "_req_drop"}, mem_req,      0);
    chk({tag, "_wbv"},      wb_valid,     1);
    chk({tag, "_wbdata"},   wb_data,      e_data);
    chk({tag, "_wbrw"},     wb_regWrite,  e_rw);
    chk({tag, "_wbrd"},     wb_rd,        rd);
    chk({tag, "_resp_rdy"}, ex_ready,     0);
    chk({tag, "_bt"},       branch_taken, 0);
    chk({tag, "_fault"},    fault,        0);
    @(posedge clk); #1;
    chk({tag, "_wbv_end"},  wb_valid, 0);
    chk({tag, "_rdy_end"},  ex_ready, 1);
  endtask

  initial begin
    //         alu           z     ovf   br    mrd   mwr   rw    rd     bt    flt   erw   eovf
    vecs[0] = '{32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0102, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0055, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0};

    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   ex_ready,     1);
    chk("rst_req",     mem_req,      0);
    chk("rst_we",      mem_we,       0);
    chk("rst_wbv",     wb_valid,     0);
    chk("rst_wbrw",    wb_regWrite,  0);
    chk("rst_bt",      branch_taken, 0);
    chk("rst_fault",   fault,        0);
    chk("rst_ovf",     wb_overflow,  0);
    chk("rst_addr",    mem_addr,     0);
    chk("rst_wdata",   mem_wdata,    0);
    chk("rst_wbdata",  wb_data,      0);
    chk("rst_wbrd",    wb_rd,        0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops: one write-back pulse per cycle.
    for (int i = 0; i < 7; i++) begin
      ex_valid     = 1'b1;
      ex_aluResult = vecs[i].alu;
      ex_zeroFlag  = vecs[i].zero;
      ex_overflow  = vecs[i].ovf;
      ex_branch    = vecs[i].br;
      ex_memRead   = vecs[i].mrd;
      ex_memWrite  = vecs[i].mwr;
      ex_regWrite  = vecs[i].rw;
      ex_rd        = vecs[i].rd;
      @(posedge clk); #1;
      chk($sformatf("v%0d_wbv", i),    wb_valid,     1);
      chk($sformatf("v%0d_data", i),   wb_data,      vecs[i].alu);
      chk($sformatf("v%0d_rd", i),     wb_rd,        vecs[i].rd);
      chk($sformatf("v%0d_rw", i),     wb_regWrite,  vecs[i].e_rw);
      chk($sformatf("v%0d_ovf", i),    wb_overflow,  vecs[i].e_ovf);
      chk($sformatf("v%0d_bt", i),     branch_taken, vecs[i].e_bt);
      chk($sformatf("v%0d_fault", i),  fault,        vecs[i].e_fault);
      chk($sformatf("v%0d_req", i),    mem_req,      0);
      chk($sformatf("v%0d_ready", i),  ex_ready,     1);
    end
    drive_idle();
    @(posedge clk); #1;
    chk("idle_wbv",   wb_valid,     0);
    chk("idle_bt",    branch_taken, 0);
    chk("idle_fault", fault,        0);

    mem_op("ldur",   32'h0000_0100, 32'h0,      32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 3,
           1'b0, 1'b1, 32'hDEAD_BEEF);
    mem_op("stur",   32'h0000_0104, 32'h1234,   32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 0,
           1'b1, 1'b0, 32'h0000_0104);
    mem_op("rdwr",   32'h0000_0108, 32'hA5A5,   32'h7777_7777, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1,
           1'b1, 1'b0, 32'h0000_0108);
    mem_op("ldbr",   32'h0000_010C, 32'h0,      32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 2,
           1'b0, 1'b1, 32'hCAFE_F00D);

    // Stray ack while idle must be ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("stray_wbv",   wb_valid, 0);
    chk("stray_req",   mem_req,  0);
    chk("stray_ready", ex_ready, 1);

    // No ack: timeout fault (or indefinite wait when timeout is not built in).
    ex_valid     = 1'b1;
    ex_aluResult = 32'h0000_0200;
    ex_memRead   = 1'b1;
    ex_regWrite  = 1'b1;
    ex_rd        = 5'd11;
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("to_req%0d", i),   mem_req,  1);
      chk($sformatf("to_fault%0d", i), fault,    0);
    end
    @(posedge clk); #1;
`ifdef EX_MEM_TIMEOUT_EN
    chk("to_req_drop", mem_req,     0);
    chk("to_fault",    fault,       1);
    chk("to_wbv",      wb_valid,    1);
    chk("to_wbrw",     wb_regWrite, 0);
    chk("to_ready",    ex_ready,    1);
    @(posedge clk); #1;
    chk("to_fault_end", fault,    0);
    chk("to_wbv_end",   wb_valid, 0);
`else
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wait_req%0d", i),   mem_req,  1);
      chk($sformatf("wait_fault%0d", i), fault,    0);
      chk($sformatf("wait_ready%0d", i), ex_ready, 0);
      @(posedge clk); #1;
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    chk("wait_wbv",  wb_valid, 1);
    chk("wait_data", wb_data,  32'h1357_9BDF);
    @(posedge clk); #1;
    chk("wait_ready_end", ex_ready, 1);
`endif

    // Reset in the middle of ACCESS abandons the request.
    ex_valid     = 1'b1;
    ex_aluResult = 32'h0000_0300;
    ex_memRead   = 1'b1;
    ex_regWrite  = 1'b1;
    ex_rd        = 5'd12;
    @(posedge clk); #1;
    drive_idle();
    chk("mr_req_pre", mem_req, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mr_req_async", mem_req,  0);
    chk("mr_ready",     ex_ready, 1);
    chk("mr_wbv",       wb_valid, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("mr_wbv_post",  wb_valid, 0);
    chk("mr_req_post",  mem_req,  0);
    @(posedge clk); #1;
    chk("mr_wbv_post2", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
